turf_udp_port_demux: RTL and testbench



---
 rtl/turf_udp_pkg.sv | 22 ++
 rtl/turf_udp_port_match.sv | 29 ++
 rtl/turf_udp_port_demux.sv | 168 ++++++++++++++++
 tb/tb_turf_udp_port_demux.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turf_udp_pkg.sv
// Shared definitions for the TURF UDP destination-port demultiplexer:
// header field offsets, FSM state type and the default port list.
package turf_udp_pkg;

  localparam int HDR_IP_OFF   = 32;
  localparam int HDR_PORT_OFF = 16;
  localparam int HDR_LEN_OFF  = 0;

  // Channel index width covers the full 1..8 channel range.
  localparam int IDX_W = 3;

  // Channel i listens on 16'h5400 + i.
  localparam logic [63:0] DEFAULT_PORT_LIST = {16'h5403, 16'h5402, 16'h5401, 16'h5400};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } demux_state_t;

endpackage

// File: rtl/turf_udp_port_match.sv
// Combinational priority match of a UDP destination port against the
// compile-time port list; the lowest matching channel index wins.
module turf_udp_port_match
  import turf_udp_pkg::*;
#(
  parameter int                      NUM_PORTS = 4,
  parameter logic [16*NUM_PORTS-1:0] PORT_LIST = DEFAULT_PORT_LIST
) (
  input  logic [15:0]      i_tdest,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top index down so a lower duplicate overrides a higher one.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (i_tdest == PORT_LIST[16*i +: 16]) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end else begin
        o_hit = o_hit;
        o_idx = o_idx;
      end
    end
  end

endmodule

// File: rtl/turf_udp_port_demux.sv
// Routes UDP datagrams (header + payload) to a per-destination-port channel;
// unlisted ports are drained. Optional macro TURF_UDP_DEMUX_STATS_EN adds drop_count.
module turf_udp_port_demux
  import turf_udp_pkg::*;
#(
  parameter int                      NUM_PORTS = 4,
  parameter logic [16*NUM_PORTS-1:0] PORT_LIST = DEFAULT_PORT_LIST
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [63:0]             s_udphdr_tdata,
  input  logic [15:0]             s_udphdr_tdest,
  input  logic                    s_udphdr_tvalid,
  output logic                    s_udphdr_tready,
  input  logic [63:0]             s_udpdata_tdata,
  input  logic [7:0]              s_udpdata_tkeep,
  input  logic                    s_udpdata_tlast,
  input  logic                    s_udpdata_tvalid,
  output logic                    s_udpdata_tready,
  output logic [64*NUM_PORTS-1:0] m_udphdr_tdata,
  output logic [NUM_PORTS-1:0]    m_udphdr_tvalid,
  input  logic [NUM_PORTS-1:0]    m_udphdr_tready,
  output logic [64*NUM_PORTS-1:0] m_udpdata_tdata,
  output logic [8*NUM_PORTS-1:0]  m_udpdata_tkeep,
  output logic [NUM_PORTS-1:0]    m_udpdata_tlast,
  output logic [NUM_PORTS-1:0]    m_udpdata_tvalid,
  input  logic [NUM_PORTS-1:0]    m_udpdata_tready
`ifdef TURF_UDP_DEMUX_STATS_EN
  ,
  output logic [31:0]             drop_count
`endif
);

  demux_state_t     r_state;
  demux_state_t     w_state_nxt;
  logic [IDX_W-1:0] r_sel;
  logic [63:0]      r_hdr;
  logic             w_hit;
  logic [IDX_W-1:0] w_idx;
  logic             w_hdr_hs;
  logic             w_sel_hdr_rdy;
  logic             w_sel_dat_rdy;

  turf_udp_port_match #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_LIST (PORT_LIST)
  ) u_match (
    .i_tdest (s_udphdr_tdest),
    .o_hit   (w_hit),
    .o_idx   (w_idx)
  );

  // Header is only taken in IDLE, and never while reset is held.
  assign s_udphdr_tready = (r_state == ST_IDLE) && !rst;
  assign w_hdr_hs        = s_udphdr_tvalid && s_udphdr_tready;

  always_comb begin
    w_sel_hdr_rdy = 1'b0;
    w_sel_dat_rdy = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_sel == IDX_W'(i)) begin
        w_sel_hdr_rdy = m_udphdr_tready[i];
        w_sel_dat_rdy = m_udpdata_tready[i];
      end else begin
        w_sel_hdr_rdy = w_sel_hdr_rdy;
        w_sel_dat_rdy = w_sel_dat_rdy;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hdr_hs) begin
          w_state_nxt = w_hit ? ST_HDR : ST_DROP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (w_sel_hdr_rdy) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_HDR;
        end
      end
      ST_DATA: begin
        if (s_udpdata_tvalid && w_sel_dat_rdy && s_udpdata_tlast) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DROP: begin
        if (s_udpdata_tvalid && s_udpdata_tlast) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DROP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_hdr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hdr_hs) begin
        r_hdr[HDR_IP_OFF +: 32]   <= s_udphdr_tdata[HDR_IP_OFF +: 32];
        r_hdr[HDR_PORT_OFF +: 16] <= s_udphdr_tdata[HDR_PORT_OFF +: 16];
        r_hdr[HDR_LEN_OFF +: 16]  <= s_udphdr_tdata[HDR_LEN_OFF +: 16];
        if (w_hit) begin
          r_sel <= w_idx;
        end else begin
          r_sel <= r_sel;
        end
      end else begin
        r_hdr <= r_hdr;
        r_sel <= r_sel;
      end
    end
  end

  // Data and header are broadcast; only the selected channel sees a valid.
  assign m_udphdr_tdata  = {NUM_PORTS{r_hdr}};
  assign m_udpdata_tdata = {NUM_PORTS{s_udpdata_tdata}};
  assign m_udpdata_tkeep = {NUM_PORTS{s_udpdata_tkeep}};
  assign m_udpdata_tlast = {NUM_PORTS{s_udpdata_tlast}};

  always_comb begin
    m_udphdr_tvalid  = '0;
    m_udpdata_tvalid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      m_udphdr_tvalid[i]  = (r_state == ST_HDR) && (r_sel == IDX_W'(i));
      m_udpdata_tvalid[i] = (r_state == ST_DATA) && (r_sel == IDX_W'(i)) && s_udpdata_tvalid;
    end
  end

  always_comb begin
    case (r_state)
      ST_DATA: s_udpdata_tready = w_sel_dat_rdy;
      ST_DROP: s_udpdata_tready = 1'b1;
      default: s_udpdata_tready = 1'b0;
    endcase
  end

`ifdef TURF_UDP_DEMUX_STATS_EN
  logic [31:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= 32'd0;
    end else if (w_hdr_hs && !w_hit && (r_drop_cnt != 32'hFFFF_FFFF)) begin
      r_drop_cnt <= r_drop_cnt + 32'd1;
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end

  assign drop_count = r_drop_cnt;
`endif

endmodule

// File: tb/tb_turf_udp_port_demux.sv
// Directed self-checking bench for turf_udp_port_demux (default port list plus
// a second instance with a duplicated port entry).
module tb_turf_udp_port_demux;

  localparam logic [63:0] DUP_LIST = {16'h5403, 16'h5400, 16'h5401, 16'h5400};

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  s_udphdr_tdata;
  logic [15:0]  s_udphdr_tdest;
  logic         s_udphdr_tvalid;
  logic         s_udphdr_tready;
  logic [63:0]  s_udpdata_tdata;
  logic [7:0]   s_udpdata_tkeep;
  logic         s_udpdata_tlast;
  logic         s_udpdata_tvalid;
  logic         s_udpdata_tready;
  logic [255:0] m_udphdr_tdata;
  logic [3:0]   m_udphdr_tvalid;
  logic [3:0]   m_udphdr_tready;
  logic [255:0] m_udpdata_tdata;
  logic [31:0]  m_udpdata_tkeep;
  logic [3:0]   m_udpdata_tlast;
  logic [3:0]   m_udpdata_tvalid;
  logic [3:0]   m_udpdata_tready;
  logic [31:0]  drop_count;

  logic         d_hdr_rdy, d_dat_rdy;
  logic [255:0] d_hdr_tdata, d_dat_tdata;
  logic [3:0]   d_hdr_tvalid, d_dat_tvalid, d_dat_tlast;
  logic [31:0]  d_dat_tkeep;
  logic [3:0]   d_all_rdy = 4'hF;
  logic [31:0]  d_drop_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [66:0] hq[$];
  logic [75:0] dq[$];
  logic [75:0] dup_q[$];
  logic [3:0]  vseen;
  logic [3:0]  dvseen;
  int          hv_first[4];

  turf_udp_port_demux dut (
    .clk(clk), .rst(rst),
    .s_udphdr_tdata(s_udphdr_tdata), .s_udphdr_tdest(s_udphdr_tdest),
    .s_udphdr_tvalid(s_udphdr_tvalid), .s_udphdr_tready(s_udphdr_tready),
    .s_udpdata_tdata(s_udpdata_tdata), .s_udpdata_tkeep(s_udpdata_tkeep),
    .s_udpdata_tlast(s_udpdata_tlast), .s_udpdata_tvalid(s_udpdata_tvalid),
    .s_udpdata_tready(s_udpdata_tready),
    .m_udphdr_tdata(m_udphdr_tdata), .m_udphdr_tvalid(m_udphdr_tvalid),
    .m_udphdr_tready(m_udphdr_tready),
    .m_udpdata_tdata(m_udpdata_tdata), .m_udpdata_tkeep(m_udpdata_tkeep),
    .m_udpdata_tlast(m_udpdata_tlast), .m_udpdata_tvalid(m_udpdata_tvalid),
    .m_udpdata_tready(m_udpdata_tready)
`ifdef TURF_UDP_DEMUX_STATS_EN
    , .drop_count(drop_count)
`endif
  );

  turf_udp_port_demux #(.NUM_PORTS(4), .PORT_LIST(DUP_LIST)) dut_dup (
    .clk(clk), .rst(rst),
    .s_udphdr_tdata(s_udphdr_tdata), .s_udphdr_tdest(s_udphdr_tdest),
    .s_udphdr_tvalid(s_udphdr_tvalid), .s_udphdr_tready(d_hdr_rdy),
    .s_udpdata_tdata(s_udpdata_tdata), .s_udpdata_tkeep(s_udpdata_tkeep),
    .s_udpdata_tlast(s_udpdata_tlast), .s_udpdata_tvalid(s_udpdata_tvalid),
    .s_udpdata_tready(d_dat_rdy),
    .m_udphdr_tdata(d_hdr_tdata), .m_udphdr_tvalid(d_hdr_tvalid),
    .m_udphdr_tready(d_all_rdy),
    .m_udpdata_tdata(d_dat_tdata), .m_udpdata_tkeep(d_dat_tkeep),
    .m_udpdata_tlast(d_dat_tlast), .m_udpdata_tvalid(d_dat_tvalid),
    .m_udpdata_tready(d_all_rdy)
`ifdef TURF_UDP_DEMUX_STATS_EN
    , .drop_count(d_drop_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are observed mid-cycle; a transfer recorded here completes at the next rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (m_udphdr_tvalid[i] || m_udpdata_tvalid[i]) vseen[i] = 1'b1;
      if (m_udphdr_tvalid[i] && hv_first[i] < 0) hv_first[i] = cyc;
      if (m_udphdr_tvalid[i] && m_udphdr_tready[i])
        hq.push_back({3'(i), m_udphdr_tdata[64*i +: 64]});
      if (m_udpdata_tvalid[i] && m_udpdata_tready[i])
        dq.push_back({3'(i), m_udpdata_tlast[i], m_udpdata_tkeep[8*i +: 8], m_udpdata_tdata[64*i +: 64]});
      if (d_hdr_tvalid[i] || d_dat_tvalid[i]) dvseen[i] = 1'b1;
      if (d_dat_tvalid[i])
        dup_q.push_back({3'(i), d_dat_tlast[i], d_dat_tkeep[8*i +: 8], d_dat_tdata[64*i +: 64]});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    hq.delete();
    dq.delete();
    dup_q.delete();
    vseen  = 4'b0000;
    dvseen = 4'b0000;
    for (int i = 0; i < 4; i++) hv_first[i] = -1;
  endtask

  // Stimulus only: present a header until accepted; acc = cycle of the accepting edge.
  task automatic send_hdr(input logic [15:0] dport, input logic [63:0] hdr, output int acc);
    logic ok;
    s_udphdr_tdata  = hdr;
    s_udphdr_tdest  = dport;
    s_udphdr_tvalid = 1'b1;
    acc = -1;
    for (int k = 0; k < 50; k++) begin
      #1;
      ok = s_udphdr_tready;
      @(posedge clk); #1;
      if (ok) begin
        acc = cyc - 1;
        break;
      end
    end
    s_udphdr_tvalid = 1'b0;
    if (acc < 0) begin
      total++; bad++;
      $display("FAIL hdr_timeout: port %h not accepted", dport);
    end
  endtask

  // Stimulus only: n payload beats base+i; rnd toggles channel 2 ready each cycle.
  task automatic send_data(input int n, input logic [63:0] base, input logic [7:0] lkeep,
                           input bit rnd, output int last_cyc, output int stalls);
    logic ok;
    bit   done;
    stalls = 0;
    for (int b = 0; b < n; b++) begin
      s_udpdata_tdata  = base + 64'(b);
      s_udpdata_tkeep  = (b == n - 1) ? lkeep : 8'hFF;
      s_udpdata_tlast  = (b == n - 1);
      s_udpdata_tvalid = 1'b1;
      done = 1'b0;
      for (int k = 0; k < 200; k++) begin
        if (rnd) m_udpdata_tready[2] = 1'($urandom_range(0, 1));
        #1;
        ok = s_udpdata_tready;
        @(posedge clk); #1;
        if (ok) begin
          done = 1'b1;
          break;
        end
        stalls++;
      end
      if (!done) begin
        total++; bad++;
        $display("FAIL data_timeout: beat %0d not accepted", b);
        break;
      end
    end
    last_cyc         = cyc - 1;
    s_udpdata_tvalid = 1'b0;
    s_udpdata_tlast  = 1'b0;
    m_udpdata_tready = 4'hF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    total++; if (s_udphdr_tready !== 1'b0) begin bad++; $display("FAIL rst_hdr_rdy: got %b want 0", s_udphdr_tready); end
    total++; if (s_udpdata_tready !== 1'b0) begin bad++; $display("FAIL rst_dat_rdy: got %b want 0", s_udpdata_tready); end
    total++; if ({m_udphdr_tvalid, m_udpdata_tvalid} !== 8'h00) begin bad++; $display("FAIL rst_valids: got %h want 00", {m_udphdr_tvalid, m_udpdata_tvalid}); end
    rst = 1'b0;
    s_udpdata_tvalid = 1'b1;
    #1;
    total++; if (s_udphdr_tready !== 1'b1) begin bad++; $display("FAIL post_rst_hdr_rdy: got %b want 1", s_udphdr_tready); end
    total++; if (s_udpdata_tready !== 1'b0) begin bad++; $display("FAIL idle_hold: got %b want 0", s_udpdata_tready); end
`ifdef TURF_UDP_DEMUX_STATS_EN
    total++; if (drop_count !== 32'd0) begin bad++; $display("FAIL rst_drop_count: got %0d want 0", drop_count); end
`endif
    s_udpdata_tvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_dup_list();
    int a, lc, st;
    clear_mon();
    send_hdr(16'h5400, 64'hC0A8_0001_1111_0010, a);
    send_data(2, 64'hD000_0000_0000_0000, 8'hFF, 1'b0, lc, st);
    total++; if (dvseen !== 4'b0001) begin bad++; $display("FAIL dup_valid_seen: got %b want 0001", dvseen); end
    total++; if (dup_q.size() !== 2) begin bad++; $display("FAIL dup_beats: got %0d want 2", dup_q.size()); end
    else if (dup_q[1] !== {3'd0, 1'b1, 8'hFF, 64'hD000_0000_0000_0001}) begin
      bad++; $display("FAIL dup_beat1: got %h want ch0 last", dup_q[1]);
    end
  endtask

  task automatic test_route_ch1();
    int a, lc, st;
    logic [63:0] h;
    logic [75:0] e;
    h = 64'h0A00_0001_1234_0020;
    clear_mon();
    m_udphdr_tready = 4'b1101;
    send_hdr(16'h5401, h, a);
    total++; if (m_udphdr_tvalid !== 4'b0010) begin bad++; $display("FAIL hdr_valid: got %b want 0010", m_udphdr_tvalid); end
    s_udpdata_tdata  = 64'hA000_0000_0000_0000;
    s_udpdata_tkeep  = 8'hFF;
    s_udpdata_tlast  = 1'b0;
    s_udpdata_tvalid = 1'b1;
    #1;
    total++; if (s_udpdata_tready !== 1'b0) begin bad++; $display("FAIL hdr_hold: got %b want 0", s_udpdata_tready); end
    @(posedge clk); #1;
    total++; if (m_udphdr_tvalid !== 4'b0010) begin bad++; $display("FAIL hdr_valid_held: got %b want 0010", m_udphdr_tvalid); end
    total++; if (m_udphdr_tdata[127:64] !== h) begin bad++; $display("FAIL hdr_stable: got %h want %h", m_udphdr_tdata[127:64], h); end
    m_udphdr_tready = 4'hF;
    send_data(3, 64'hA000_0000_0000_0000, 8'h0F, 1'b0, lc, st);
    total++; if (hv_first[1] !== a + 1) begin bad++; $display("FAIL hdr_latency: got %0d want %0d", hv_first[1], a + 1); end
    total++; if (st !== 1) begin bad++; $display("FAIL data_stalls: got %0d want 1", st); end
    total++; if (hq.size() !== 1) begin bad++; $display("FAIL hdr_count: got %0d want 1", hq.size()); end
    else if (hq[0] !== {3'd1, h}) begin bad++; $display("FAIL hdr_out: got %h want %h", hq[0], {3'd1, h}); end
    total++; if (dq.size() !== 3) begin bad++; $display("FAIL beat_count: got %0d want 3", dq.size()); end
    else begin
      for (int j = 0; j < 3; j++) begin
        e = {3'd1, (j == 2), (j == 2) ? 8'h0F : 8'hFF, 64'hA000_0000_0000_0000 + 64'(j)};
        total++; if (dq[j] !== e) begin bad++; $display("FAIL ch1_beat%0d: got %h want %h", j, dq[j], e); end
      end
    end
    total++; if ((vseen & 4'b1101) !== 4'b0000) begin bad++; $display("FAIL other_ch_valid: got %b want 0000", vseen & 4'b1101); end
  endtask

  task automatic test_drop();
    int a, lc, st, c1;
    clear_mon();
    send_hdr(16'h1234, 64'h0A00_0002_4321_0028, a);
    c1 = cyc;
    send_data(5, 64'hB000_0000_0000_0000, 8'h01, 1'b0, lc, st);
    total++; if (st !== 0) begin bad++; $display("FAIL drop_stalls: got %0d want 0", st); end
    total++; if (cyc - c1 !== 5) begin bad++; $display("FAIL drop_cycles: got %0d want 5", cyc - c1); end
    total++; if (vseen !== 4'b0000) begin bad++; $display("FAIL drop_valid: got %b want 0000", vseen); end
    total++; if (hq.size() + dq.size() !== 0) begin bad++; $display("FAIL drop_out: got %0d want 0", hq.size() + dq.size()); end
`ifdef TURF_UDP_DEMUX_STATS_EN
    total++; if (drop_count !== 32'd1) begin bad++; $display("FAIL drop_count: got %0d want 1", drop_count); end
`endif
  endtask

  task automatic test_stall_ch2();
    int a, lc, st;
    logic [75:0] e;
    clear_mon();
    send_hdr(16'h5402, 64'h0A00_0003_5555_0088, a);
    send_data(16, 64'hC000_0000_0000_0100, 8'hFF, 1'b1, lc, st);
    total++; if (vseen !== 4'b0100) begin bad++; $display("FAIL stall_valid: got %b want 0100", vseen); end
    total++; if (st < 1) begin bad++; $display("FAIL stall_count: got %0d want >=1", st); end
    total++; if (dq.size() !== 16) begin bad++; $display("FAIL stall_beats: got %0d want 16", dq.size()); end
    else begin
      for (int j = 0; j < 16; j++) begin
        e = {3'd2, (j == 15), 8'hFF, 64'hC000_0000_0000_0100 + 64'(j)};
        total++; if (dq[j] !== e) begin bad++; $display("FAIL stall_beat%0d: got %h want %h", j, dq[j], e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2, lc1, lc2, st;
    clear_mon();
    send_hdr(16'h5400, 64'h0A00_0004_0001_0010, a1);
    send_data(2, 64'hE000_0000_0000_0000, 8'hFF, 1'b0, lc1, st);
    send_hdr(16'h5403, 64'h0A00_0005_0002_0009, a2);
    send_data(1, 64'hF000_0000_0000_0000, 8'h01, 1'b0, lc2, st);
    total++; if (a2 !== lc1 + 1) begin bad++; $display("FAIL b2b_accept: got %0d want %0d", a2, lc1 + 1); end
    total++; if (hq.size() !== 2) begin bad++; $display("FAIL b2b_hdrs: got %0d want 2", hq.size()); end
    else if (hq[1] !== {3'd3, 64'h0A00_0005_0002_0009}) begin bad++; $display("FAIL b2b_hdr2: got %h want ch3", hq[1]); end
    total++; if (dq.size() !== 3) begin bad++; $display("FAIL b2b_beats: got %0d want 3", dq.size()); end
    else if (dq[2] !== {3'd3, 1'b1, 8'h01, 64'hF000_0000_0000_0000}) begin bad++; $display("FAIL b2b_beat3: got %h want ch3 last", dq[2]); end
  endtask

  task automatic test_reset_mid();
    int a, lc, st;
    logic ok;
    clear_mon();
    send_hdr(16'h5400, 64'h0A00_0006_0003_0020, a);
    s_udpdata_tdata  = 64'h1111_0000_0000_0000;
    s_udpdata_tkeep  = 8'hFF;
    s_udpdata_tlast  = 1'b0;
    s_udpdata_tvalid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1; ok = s_udpdata_tready;
      @(posedge clk); #1;
      if (ok) break;
    end
    s_udpdata_tdata = 64'h1111_0000_0000_0001;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if ({m_udphdr_tvalid, m_udpdata_tvalid} !== 8'h00) begin bad++; $display("FAIL mid_rst_valids: got %h want 00", {m_udphdr_tvalid, m_udpdata_tvalid}); end
    total++; if (s_udpdata_tready !== 1'b0) begin bad++; $display("FAIL mid_rst_dat_rdy: got %b want 0", s_udpdata_tready); end
    rst = 1'b0;
    s_udpdata_tvalid = 1'b0;
    #1;
    total++; if (s_udphdr_tready !== 1'b1) begin bad++; $display("FAIL mid_rst_idle: got %b want 1", s_udphdr_tready); end
`ifdef TURF_UDP_DEMUX_STATS_EN
    total++; if (drop_count !== 32'd0) begin bad++; $display("FAIL mid_rst_drop_count: got %0d want 0", drop_count); end
`endif
    @(posedge clk); #1;
    clear_mon();
    send_hdr(16'h5403, 64'h0A00_0007_0004_0010, a);
    send_data(2, 64'h2222_0000_0000_0000, 8'h03, 1'b0, lc, st);
    total++; if (vseen !== 4'b1000) begin bad++; $display("FAIL after_rst_valid: got %b want 1000", vseen); end
    total++; if (dq.size() !== 2) begin bad++; $display("FAIL after_rst_beats: got %0d want 2", dq.size()); end
    else if (dq[1] !== {3'd3, 1'b1, 8'h03, 64'h2222_0000_0000_0001}) begin bad++; $display("FAIL after_rst_beat1: got %h want ch3 last", dq[1]); end
  endtask

  initial begin
    rst              = 1'b1;
    s_udphdr_tdata   = 64'h0;
    s_udphdr_tdest   = 16'h0;
    s_udphdr_tvalid  = 1'b0;
    s_udpdata_tdata  = 64'h0;
    s_udpdata_tkeep  = 8'h00;
    s_udpdata_tlast  = 1'b0;
    s_udpdata_tvalid = 1'b0;
    m_udphdr_tready  = 4'hF;
    m_udpdata_tready = 4'hF;
    clear_mon();
    test_reset();
    test_dup_list();
    test_route_ch1();
    test_drop();
    test_stall_ch2();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
